// File: rtl/sram_arbiter_pkg.sv
// Shared CPU bus definitions for the SRAM-like arbiter.
//   owner_t    : tag stored per outstanding request (0 = IF, 1 = MEM)
//   SIZE_*     : SRAM-like access size codes
//   sram_req_t : one master's request channel bundled for muxing
package sram_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Signal bundle between the two CPU masters, the arbiter and the shared
// SRAM-like slave.
//   slave  : arbiter view (accepts inst/data requests, drives the bus side)
//   master : environment view (drives master requests and slave responses)
interface sram_arbiter_if;

    logic        inst_sram_req,   data_sram_req;
    logic        inst_sram_wr,    data_sram_wr;
    logic [1:0]  inst_sram_size,  data_sram_size;
    logic [3:0]  inst_sram_wstrb, data_sram_wstrb;
    logic [31:0] inst_sram_addr,  data_sram_addr;
    logic [31:0] inst_sram_wdata, data_sram_wdata;
    logic        inst_sram_addr_ok, data_sram_addr_ok;
    logic        inst_sram_data_ok, data_sram_data_ok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;

    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );

endinterface

// File: rtl/sram_arbiter_ot_fifo.sv
// Outstanding-transaction owner FIFO: remembers which master owns each
// accepted request so in-order responses can be routed back.
//   clk, resetn : clock, async active-low reset (clears pointers/count)
//   push/push_id: enqueue owner tag (ignored when full)
//   pop         : dequeue head (ignored when empty)
//   head        : owner of the oldest outstanding request
//   full/empty/count : occupancy
module ot_fifo
    import sram_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  owner_t        push_id,
    input  logic          pop,
    output owner_t        head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    owner_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_id;
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap by overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (IF / MEM) to one-slave SRAM-like bus arbiter.
//   clk, resetn : clock, async active-low reset
//   sif         : slave modport of sram_arbiter_if (master channels + bus)
// Data master wins ties; a stalled request (bus_req & !bus_addr_ok) locks
// the grant until accepted. Accepted owners are queued so in-order bus
// responses are steered to the right master with no added latency.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int OT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    sram_arbiter_if.slave  sif
);

    localparam int CW = $clog2(OT_DEPTH) + 1;

    sram_req_t       inst_r, data_r, sel_r;
    owner_t          grant, lock_owner, head;
    logic            locked;
    logic            full, empty, accept, pop;
    logic [CW-1:0]   ot_count;
    logic            proto_err;

    assign inst_r = '{sif.inst_sram_req, sif.inst_sram_wr, sif.inst_sram_size,
                      sif.inst_sram_wstrb, sif.inst_sram_addr, sif.inst_sram_wdata};
    assign data_r = '{sif.data_sram_req, sif.data_sram_wr, sif.data_sram_size,
                      sif.data_sram_wstrb, sif.data_sram_addr, sif.data_sram_wdata};

    // A stalled request keeps the bus fields stable until the slave takes it.
    always_comb begin
        grant = locked ? lock_owner : (data_r.req ? OWNER_DATA : OWNER_INST);
        sel_r = (grant == OWNER_DATA) ? data_r : inst_r;
    end

    assign sif.bus_req   = sel_r.req & ~full & resetn;
    assign sif.bus_wr    = sel_r.wr;
    assign sif.bus_size  = sel_r.size;
    assign sif.bus_wstrb = sel_r.wstrb;
    assign sif.bus_addr  = sel_r.addr;
    assign sif.bus_wdata = sel_r.wdata;

    assign accept = sif.bus_req & sif.bus_addr_ok;
    assign pop    = sif.bus_data_ok & ~empty & resetn;

    assign sif.inst_sram_addr_ok = accept & (grant == OWNER_INST);
    assign sif.data_sram_addr_ok = accept & (grant == OWNER_DATA);
    assign sif.inst_sram_data_ok = pop & (head == OWNER_INST);
    assign sif.data_sram_data_ok = pop & (head == OWNER_DATA);
    assign sif.inst_sram_rdata   = sif.bus_rdata;
    assign sif.data_sram_rdata   = sif.bus_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked     <= 1'b0;
            lock_owner <= OWNER_INST;
        end else begin
            locked     <= sif.bus_req & ~sif.bus_addr_ok;
            lock_owner <= grant;
        end
    end

    // A response with nothing outstanding is a slave protocol violation;
    // it is dropped and remembered until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            proto_err <= 1'b0;
        else if (sif.bus_data_ok && ot_count == '0)
            proto_err <= 1'b1;
    end

    ot_fifo #(.DEPTH(OT_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (grant),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (ot_count)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int OT = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if sif();
    sram_arbiter #(.OT_DEPTH(OT)) dut (.clk(clk), .resetn(resetn), .sif(sif));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // q: owners of accepted-but-unanswered requests, oldest first.
    // held: master whose stalled request must stay on the bus (-1 = none).
    int q[$];
    int held = -1;
    bit merr = 1'b0;
    int acc_i = 0, acc_d = 0, dok_i = 0, dok_d = 0;

    always @(negedge clk) begin : compare
        int  g;
        bit  greq, ebr, acc, full_m;
        if (!resetn) begin
            chk("rst_bus_req", sif.bus_req, 0);
            chk("rst_i_aok", sif.inst_sram_addr_ok, 0);
            chk("rst_d_aok", sif.data_sram_addr_ok, 0);
            chk("rst_i_dok", sif.inst_sram_data_ok, 0);
            chk("rst_d_dok", sif.data_sram_data_ok, 0);
            chk("rst_err", dut.proto_err, 0);
            q.delete();
            held = -1;
            merr = 1'b0;
        end else begin
            full_m = (q.size() == OT);
            g      = (held >= 0) ? held : (sif.data_sram_req ? 1 : 0);
            greq   = g ? sif.data_sram_req : sif.inst_sram_req;
            ebr    = greq && !full_m;
            acc    = ebr && sif.bus_addr_ok;
            chk("bus_req", sif.bus_req, ebr);
            chk("i_addr_ok", sif.inst_sram_addr_ok, acc && g == 0);
            chk("d_addr_ok", sif.data_sram_addr_ok, acc && g == 1);
            if (ebr) begin
                chk("bus_addr",  sif.bus_addr,  g ? sif.data_sram_addr  : sif.inst_sram_addr);
                chk("bus_wdata", sif.bus_wdata, g ? sif.data_sram_wdata : sif.inst_sram_wdata);
                chk("bus_wr",    sif.bus_wr,    g ? sif.data_sram_wr    : sif.inst_sram_wr);
                chk("bus_size",  sif.bus_size,  g ? sif.data_sram_size  : sif.inst_sram_size);
                chk("bus_wstrb", sif.bus_wstrb, g ? sif.data_sram_wstrb : sif.inst_sram_wstrb);
            end
            chk("i_data_ok", sif.inst_sram_data_ok, sif.bus_data_ok && q.size() > 0 && q[0] == 0);
            chk("d_data_ok", sif.data_sram_data_ok, sif.bus_data_ok && q.size() > 0 && q[0] == 1);
            chk("i_rdata", sif.inst_sram_rdata, sif.bus_rdata);
            chk("d_rdata", sif.data_sram_rdata, sif.bus_rdata);
            chk("count", 32'(dut.u_fifo.count), q.size());
            chk("err", dut.proto_err, merr);
            if (sif.inst_sram_addr_ok) acc_i++;
            if (sif.data_sram_addr_ok) acc_d++;
            if (sif.inst_sram_data_ok) dok_i++;
            if (sif.data_sram_data_ok) dok_d++;
            if (sif.bus_data_ok) begin
                if (q.size() == 0) merr = 1'b1;
                else void'(q.pop_front());
            end
            if (acc) q.push_back(g);
            held = (ebr && !sif.bus_addr_ok) ? g : -1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic idle();
        sif.inst_sram_req = 0; sif.inst_sram_wr = 0; sif.inst_sram_size = SIZE_WORD;
        sif.inst_sram_wstrb = 4'h0; sif.inst_sram_addr = 32'h0; sif.inst_sram_wdata = 32'h0;
        sif.data_sram_req = 0; sif.data_sram_wr = 1; sif.data_sram_size = SIZE_WORD;
        sif.data_sram_wstrb = 4'hf; sif.data_sram_addr = 32'h0; sif.data_sram_wdata = 32'hdeadbeef;
        sif.bus_addr_ok = 0; sif.bus_data_ok = 0; sif.bus_rdata = 32'h0;
    endtask

    initial begin
        idle();
        // Reset: requests present but everything gated off.
        sif.inst_sram_req = 1; sif.bus_addr_ok = 1; sif.bus_data_ok = 1;
        mid();
        chk("L_rst_bus_req", sif.bus_req, 0);
        chk("L_rst_i_aok", sif.inst_sram_addr_ok, 0);
        chk("L_rst_i_dok", sif.inst_sram_data_ok, 0);
        chk("L_rst_count", 32'(dut.u_fifo.count), 0);
        nxt();
        // First acceptance on the first rising edge after release.
        resetn = 1; sif.bus_data_ok = 0; sif.inst_sram_addr = 32'h100;
        mid();
        chk("L_first_accept", sif.inst_sram_addr_ok, 1);
        nxt();
        sif.inst_sram_req = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h11;
        mid();
        chk("L_first_dok", sif.inst_sram_data_ok, 1);
        nxt();
        idle();

        // Priority: data before inst, responses routed in order.
        sif.inst_sram_req = 1; sif.inst_sram_addr = 32'h1c000000;
        sif.data_sram_req = 1; sif.data_sram_addr = 32'h00001000; sif.bus_addr_ok = 1;
        mid();
        chk("L_pri_addr", sif.bus_addr, 32'h00001000);
        chk("L_pri_d_aok", sif.data_sram_addr_ok, 1);
        chk("L_pri_i_aok", sif.inst_sram_addr_ok, 0);
        nxt();
        sif.data_sram_req = 0;
        mid();
        chk("L_pri_addr2", sif.bus_addr, 32'h1c000000);
        chk("L_pri_i_aok2", sif.inst_sram_addr_ok, 1);
        nxt();
        sif.inst_sram_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'haaaa;
        mid();
        chk("L_pri_d_dok", sif.data_sram_data_ok, 1);
        chk("L_pri_rdata", sif.data_sram_rdata, 32'haaaa);
        nxt();
        sif.bus_rdata = 32'hbbbb;
        mid();
        chk("L_pri_i_dok", sif.inst_sram_data_ok, 1);
        chk("L_pri_d_dok2", sif.data_sram_data_ok, 0);
        nxt();
        idle();

        // Lock: stalled inst request keeps the bus against a new data request.
        sif.inst_sram_req = 1; sif.inst_sram_addr = 32'h1c000000;
        mid();
        chk("L_lock_addr0", sif.bus_addr, 32'h1c000000);
        nxt();
        sif.data_sram_req = 1; sif.data_sram_addr = 32'h00002000;
        mid();
        chk("L_lock_addr1", sif.bus_addr, 32'h1c000000);
        nxt();
        mid();
        chk("L_lock_addr2", sif.bus_addr, 32'h1c000000);
        nxt();
        sif.bus_addr_ok = 1;
        mid();
        chk("L_lock_i_aok", sif.inst_sram_addr_ok, 1);
        nxt();
        sif.inst_sram_req = 0;
        mid();
        chk("L_lock_d_aok", sif.data_sram_addr_ok, 1);
        nxt();
        sif.data_sram_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1;
        mid();
        chk("L_lock_dok_i", sif.inst_sram_data_ok, 1);
        nxt();
        mid();
        chk("L_lock_dok_d", sif.data_sram_data_ok, 1);
        nxt();
        idle();

        // Full: four accepts, fifth blocked; pop while full does not re-open.
        sif.inst_sram_req = 1; sif.inst_sram_addr = 32'h1c000010; sif.bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("L_fill_aok", sif.inst_sram_addr_ok, 1);
            nxt();
        end
        mid();
        chk("L_full_bus_req", sif.bus_req, 0);
        chk("L_full_count", 32'(dut.u_fifo.count), 4);
        nxt();
        sif.bus_data_ok = 1;
        mid();
        chk("L_fullpop_bus_req", sif.bus_req, 0);
        chk("L_fullpop_i_dok", sif.inst_sram_data_ok, 1);
        nxt();
        sif.bus_data_ok = 0; sif.inst_sram_req = 0;
        sif.data_sram_req = 1; sif.data_sram_addr = 32'h00003000;
        mid();
        chk("L_reopen_bus_req", sif.bus_req, 1);
        chk("L_reopen_d_aok", sif.data_sram_addr_ok, 1);
        nxt();
        // Queue now I,I,I,D. Pop while full with a pending request.
        sif.data_sram_req = 0; sif.inst_sram_req = 1; sif.bus_data_ok = 1;
        mid();
        chk("L_fp_aok", sif.inst_sram_addr_ok, 0);
        chk("L_fp_i_dok", sif.inst_sram_data_ok, 1);
        chk("L_fp_count", 32'(dut.u_fifo.count), 4);
        nxt();
        // Push and pop together at count 3.
        mid();
        chk("L_pp_aok", sif.inst_sram_addr_ok, 1);
        chk("L_pp_dok", sif.inst_sram_data_ok, 1);
        chk("L_pp_count", 32'(dut.u_fifo.count), 3);
        nxt();
        sif.inst_sram_req = 0; sif.bus_addr_ok = 0;
        mid();
        chk("L_pp_count2", 32'(dut.u_fifo.count), 3);
        chk("L_drain1", sif.inst_sram_data_ok, 1);
        nxt();
        mid();
        chk("L_drain2", sif.data_sram_data_ok, 1);
        nxt();
        mid();
        chk("L_drain3", sif.inst_sram_data_ok, 1);
        nxt();
        sif.bus_data_ok = 0;
        mid();
        chk("L_drained", 32'(dut.u_fifo.count), 0);
        nxt();

        // Reset mid-cycle with two outstanding, then a stray response.
        sif.inst_sram_req = 1; sif.bus_addr_ok = 1;
        nxt();
        sif.inst_sram_req = 0; sif.data_sram_req = 1;
        nxt();
        sif.data_sram_req = 0; sif.inst_sram_req = 1; sif.bus_addr_ok = 0;
        #1;
        chk("L_pre_rst_count", 32'(dut.u_fifo.count), 2);
        chk("L_pre_rst_bus_req", sif.bus_req, 1);
        #2;
        resetn = 0; sif.bus_data_ok = 1;
        #1;
        chk("L_async_bus_req", sif.bus_req, 0);
        chk("L_async_i_dok", sif.inst_sram_data_ok, 0);
        chk("L_async_count", 32'(dut.u_fifo.count), 0);
        nxt();
        resetn = 1; sif.inst_sram_req = 0;
        mid();
        chk("L_stray_i_dok", sif.inst_sram_data_ok, 0);
        chk("L_stray_d_dok", sif.data_sram_data_ok, 0);
        nxt();
        sif.bus_data_ok = 0;
        mid();
        chk("L_stray_err", dut.proto_err, 1);
        chk("L_stray_count", 32'(dut.u_fifo.count), 0);
        nxt();
        resetn = 0;
        nxt();
        resetn = 1;
        acc_i = 0; acc_d = 0; dok_i = 0; dok_d = 0;

        // Random interleaved traffic; the compare process checks every cycle.
        for (int c = 0; c < 10000; c++) begin
            sif.inst_sram_req   = ($urandom_range(0, 1) == 1);
            sif.data_sram_req   = ($urandom_range(0, 2) == 0);
            sif.inst_sram_addr  = $urandom; sif.data_sram_addr = $urandom;
            sif.inst_sram_wdata = $urandom; sif.data_sram_wdata = $urandom;
            sif.data_sram_wr    = 1'($urandom); sif.data_sram_size = 2'($urandom_range(0, 2));
            sif.data_sram_wstrb = 4'($urandom);
            sif.bus_addr_ok     = ($urandom_range(0, 4) < 3);
            sif.bus_data_ok     = (q.size() > 0) && ($urandom_range(0, 4) < 2);
            sif.bus_rdata       = $urandom;
            nxt();
        end
        sif.inst_sram_req = 0; sif.data_sram_req = 0; sif.bus_addr_ok = 0;
        for (int c = 0; c < 50 && q.size() > 0; c++) begin
            sif.bus_data_ok = 1;
            nxt();
        end
        sif.bus_data_ok = 0;
        mid();
        chk("rnd_drain", q.size(), 0);
        chk("rnd_inst_balance", dok_i, acc_i);
        chk("rnd_data_balance", dok_d, acc_d);
        chk("rnd_inst_seen", acc_i > 100, 1);
        chk("rnd_data_seen", acc_d > 100, 1);
        chk("rnd_err", dut.proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
